// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh flit types, sizing constants and the injector's packet descriptor
package noc_pkg;

    localparam int VC_NUM            = 2;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int HEAD_PAYLOAD_SIZE = 16;
    localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;
    localparam int PKT_LEN_SIZE      = 8;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [PKT_LEN_SIZE-1:0]      len;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } pkt_desc_t;

    // A zero-length request still carries a head, so it becomes a single HEADTAIL flit
    function automatic logic [PKT_LEN_SIZE-1:0] clamp_len(input logic [PKT_LEN_SIZE-1:0] len, input int max_len);
        return len == '0 ? PKT_LEN_SIZE'(1) : (int'(len) > max_len ? PKT_LEN_SIZE'(max_len) : len);
    endfunction

endpackage

// File: rtl/node_packet_injector_if.sv
// node_packet_injector_if: descriptor, payload and router local-port signals of one injector
interface node_packet_injector_if #(parameter int MAX_PKT_LEN = 16);
    import noc_pkg::*;

    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0]  req_x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0]  req_y_dest_i;
    logic [LEN_W-1:0]             req_len_i;
    logic [HEAD_PAYLOAD_SIZE-1:0] req_head_pl_i;
    logic                         pl_valid_i;
    logic                         pl_ready_o;
    logic [FLIT_DATA_SIZE-1:0]    pl_data_i;
    flit_t                        data_o;
    logic                         is_valid_o;
    logic [VC_NUM-1:0]            is_on_off_i;
    logic [VC_NUM-1:0]            is_allocatable_i;

    modport slave (
        input  req_valid_i, req_x_dest_i, req_y_dest_i, req_len_i, req_head_pl_i,
        input  pl_valid_i, pl_data_i, is_on_off_i, is_allocatable_i,
        output req_ready_o, pl_ready_o, data_o, is_valid_o
    );

    modport master (
        output req_valid_i, req_x_dest_i, req_y_dest_i, req_len_i, req_head_pl_i,
        output pl_valid_i, pl_data_i, is_on_off_i, is_allocatable_i,
        input  req_ready_o, pl_ready_o, data_o, is_valid_o
    );

endinterface

// File: rtl/pkt_desc_fifo.sv
// pkt_desc_fifo: synchronous packet-descriptor FIFO with full/empty flags
module pkt_desc_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  pkt_desc_t push_data,
    input  logic      pop,
    output pkt_desc_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    pkt_desc_t   mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/node_packet_injector.sv
// node_packet_injector: segments queued packet descriptors plus a payload stream into
// HEAD/BODY/TAIL flits for one mesh node's local router port.
module node_packet_injector
    import noc_pkg::*;
#(
    parameter int MAX_PKT_LEN    = 16,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    node_packet_injector_if.slave bus,
    output logic                  busy_o,
    output logic [15:0]           pkt_sent_o
);

    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_VC_ALLOC, S_HEAD, S_BODY} state_t;

    state_t             state;
    pkt_desc_t          req_desc, cur_desc;
    logic               full, empty, push, pop;
    logic               vc_on, head_fire, body_fire, grant_found;
    logic [VC_SIZE-1:0] vc, rr_ptr, grant_vc;
    logic [VC_NUM-1:0]  cand;
    logic [LEN_W-1:0]   remaining;
    flit_t              flit_q;
    logic               valid_q;

    assign req_desc = '{
        x_dest:  bus.req_x_dest_i,
        y_dest:  bus.req_y_dest_i,
        len:     clamp_len(PKT_LEN_SIZE'(bus.req_len_i), MAX_PKT_LEN),
        head_pl: bus.req_head_pl_i
    };

    assign bus.req_ready_o = !full && !rst;
    assign push            = bus.req_valid_i && bus.req_ready_o;

    pkt_desc_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req_desc),
        .pop       (pop),
        .head      (cur_desc),
        .full      (full),
        .empty     (empty)
    );

    assign vc_on          = bus.is_on_off_i[vc];
    assign head_fire      = state == S_HEAD && vc_on;
    assign body_fire      = state == S_BODY && vc_on && bus.pl_valid_i;
    assign bus.pl_ready_o = body_fire;
    assign pop            = (head_fire && cur_desc.len == PKT_LEN_SIZE'(1)) ||
                            (body_fire && remaining == LEN_W'(1));
    assign cand           = bus.is_allocatable_i & bus.is_on_off_i;
    assign busy_o         = state != S_IDLE || !empty;
    assign bus.data_o     = flit_q;
    assign bus.is_valid_o = valid_q;

    // Walk from the farthest candidate back toward rr_ptr so the nearest one wins
    always_comb begin
        grant_found = 1'b0;
        grant_vc    = rr_ptr;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (cand[(int'(rr_ptr) + i) % VC_NUM]) begin
                grant_found = 1'b1;
                grant_vc    = VC_SIZE'((int'(rr_ptr) + i) % VC_NUM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            vc         <= '0;
            remaining  <= '0;
            flit_q     <= '0;
            valid_q    <= 1'b0;
            pkt_sent_o <= '0;
        end else begin
            valid_q <= head_fire || body_fire;
            if (pop) pkt_sent_o <= pkt_sent_o + 16'd1;
            case (state)
                S_IDLE: if (!empty) state <= S_VC_ALLOC;
                S_VC_ALLOC: if (grant_found) begin
                    vc     <= grant_vc;
                    rr_ptr <= grant_vc == VC_SIZE'(VC_NUM - 1) ? '0 : grant_vc + VC_SIZE'(1);
                    state  <= S_HEAD;
                end
                S_HEAD: if (head_fire) begin
                    flit_q    <= {pop ? HEADTAIL : HEAD, vc, cur_desc.x_dest, cur_desc.y_dest, cur_desc.head_pl};
                    remaining <= LEN_W'(cur_desc.len - PKT_LEN_SIZE'(1));
                    state     <= pop ? S_IDLE : S_BODY;
                end
                S_BODY: if (body_fire) begin
                    flit_q    <= {pop ? TAIL : BODY, vc, bus.pl_data_i};
                    remaining <= remaining - LEN_W'(1);
                    if (pop) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_packet_injector.sv
// tb_node_packet_injector: directed checks of flit segmentation, VC round-robin,
// backpressure, descriptor FIFO limits and mid-packet reset.
module tb_node_packet_injector;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] pkt_sent;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          pl_cnt = 0;
    logic        take = 1'b0;
    flit_t       flits[$];
    int          fcyc[$];

    node_packet_injector_if #(.MAX_PKT_LEN(16)) bus ();

    node_packet_injector #(.MAX_PKT_LEN(16), .REQ_FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy_o     (busy),
        .pkt_sent_o (pkt_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.is_valid_o) begin
            flits.push_back(bus.data_o);
            fcyc.push_back(cyc);
        end
        take = bus.pl_valid_i && bus.pl_ready_o;
        if (take) pl_cnt++;
    end

    // Payload source: 0x100, 0x101, ... advancing on every consumed beat
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) bus.pl_data_i <= 24'h100;
        else if (take) bus.pl_data_i <= bus.pl_data_i + 24'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int x, input int y, input int len, input int pl);
        bus.req_x_dest_i  = 4'(x);
        bus.req_y_dest_i  = 4'(y);
        bus.req_len_i     = 5'(len);
        bus.req_head_pl_i = 16'(pl);
        bus.req_valid_i   = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                @(posedge clk);
                #1;
                bus.req_valid_i = 1'b0;
                return;
            end
        end
        check("push_timeout", 32'(bus.req_ready_o), 1);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_flits(input int n);
        for (int t = 0; t < 500; t++) begin
            if (flits.size() >= n) return;
            @(posedge clk);
        end
        check("flit_timeout", flits.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int p0;
        int vexp[3];
        bus.req_valid_i      = 1'b0;
        bus.req_x_dest_i     = '0;
        bus.req_y_dest_i     = '0;
        bus.req_len_i        = '0;
        bus.req_head_pl_i    = '0;
        bus.pl_valid_i       = 1'b0;
        bus.is_on_off_i      = 2'b11;
        bus.is_allocatable_i = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(bus.is_valid_o), 0);
        check("rst_data", 32'(bus.data_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sent", 32'(pkt_sent), 0);
        check("rst_ready", 32'(bus.req_ready_o), 1);

        // Single-flit packet
        @(posedge clk); #1;
        push_req(1, 2, 1, 'hABCD);
        wait_flits(1);
        idle(6);
        check("t1_count", flits.size(), 1);
        check("t1_label", 32'(flits[0].flit_label), 32'(HEADTAIL));
        check("t1_vc", 32'(flits[0].vc_id), 0);
        check("t1_x", 32'(flits[0].data.head_data.x_dest), 1);
        check("t1_y", 32'(flits[0].data.head_data.y_dest), 2);
        check("t1_pl", 32'(flits[0].data.head_data.head_pl), 'hABCD);
        check("t1_sent", 32'(pkt_sent), 1);
        check("t1_busy", 32'(busy), 0);

        // Four-flit packet, payload always available; pointer now at VC1
        b  = flits.size();
        p0 = pl_cnt;
        bus.pl_valid_i = 1'b1;
        push_req(3, 1, 4, 'h1111);
        wait_flits(b + 4);
        idle(4);
        check("t2_count", flits.size(), b + 4);
        check("t2_lbl0", 32'(flits[b].flit_label), 32'(HEAD));
        check("t2_lbl1", 32'(flits[b+1].flit_label), 32'(BODY));
        check("t2_lbl2", 32'(flits[b+2].flit_label), 32'(BODY));
        check("t2_lbl3", 32'(flits[b+3].flit_label), 32'(TAIL));
        for (int i = 0; i < 4; i++) check("t2_vc", 32'(flits[b+i].vc_id), 1);
        check("t2_span", fcyc[b+3] - fcyc[b], 3);
        check("t2_pl1", 32'(flits[b+1].data.bt_pl), 'h100);
        check("t2_pl3", 32'(flits[b+3].data.bt_pl), 'h102);
        check("t2_plready", pl_cnt - p0, 3);
        check("t2_sent", 32'(pkt_sent), 2);

        // Backpressure on VC0 for five cycles right after the first body flit issues
        b = flits.size();
        push_req(2, 2, 4, 'h2222);
        wait_flits(b + 1);
        #1 bus.is_on_off_i = 2'b10;
        idle(5);
        check("t3_stalled", flits.size(), b + 2);
        bus.is_on_off_i = 2'b11;
        wait_flits(b + 4);
        idle(3);
        check("t3_count", flits.size(), b + 4);
        check("t3_vc", 32'(flits[b].vc_id), 0);
        check("t3_gap", fcyc[b+2] - fcyc[b+1], 6);
        check("t3_tail_gap", fcyc[b+3] - fcyc[b+2], 1);
        check("t3_pl1", 32'(flits[b+1].data.bt_pl), 'h103);
        check("t3_pl2", 32'(flits[b+2].data.bt_pl), 'h104);
        check("t3_pl3", 32'(flits[b+3].data.bt_pl), 'h105);
        check("t3_lbl3", 32'(flits[b+3].flit_label), 32'(TAIL));
        check("t3_sent", 32'(pkt_sent), 3);

        // Round-robin with both VCs free: pointer is at VC1
        vexp = '{1, 0, 1};
        b = flits.size();
        for (int i = 0; i < 3; i++) push_req(i, 0, 1, i);
        wait_flits(b + 3);
        idle(4);
        for (int i = 0; i < 3; i++) check("t4_rr_vc", 32'(flits[b+i].vc_id), vexp[i]);

        // VC1 not allocatable: every packet lands on VC0
        bus.is_allocatable_i = 2'b01;
        b = flits.size();
        for (int i = 0; i < 3; i++) push_req(i, 1, 1, i);
        wait_flits(b + 3);
        idle(4);
        for (int i = 0; i < 3; i++) check("t4_vc0", 32'(flits[b+i].vc_id), 0);
        check("t4_gap", fcyc[b+1] - fcyc[b], 3);
        check("t4_sent", 32'(pkt_sent), 9);
        bus.is_allocatable_i = 2'b11;

        // FIFO fills while no VC can be allocated; fifth descriptor waits for a pop
        bus.is_allocatable_i = 2'b00;
        b = flits.size();
        for (int i = 0; i < 4; i++) push_req(i + 8, 0, 1, 0);
        @(negedge clk);
        check("t5_full_ready", 32'(bus.req_ready_o), 0);
        check("t5_busy", 32'(busy), 1);
        check("t5_no_flits", flits.size(), b);
        @(posedge clk); #1;
        bus.is_allocatable_i = 2'b11;
        push_req(4, 4, 20, 'h5555);
        check("t5_after_pop", flits.size() - b, 1);
        wait_flits(b + 20);
        idle(5);
        check("t5_count", flits.size(), b + 20);
        check("t5_head", 32'(flits[b+4].flit_label), 32'(HEAD));
        check("t5_head_x", 32'(flits[b+4].data.head_data.x_dest), 4);
        check("t5_body", 32'(flits[b+18].flit_label), 32'(BODY));
        check("t5_tail", 32'(flits[b+19].flit_label), 32'(TAIL));
        check("t5_sent", 32'(pkt_sent), 14);

        // Reset in the middle of a packet, then a zero-length request
        b = flits.size();
        push_req(7, 7, 6, 'h7777);
        wait_flits(b + 1);
        #1 bus.pl_valid_i = 1'b0;
        idle(2);
        check("t6_busy_mid", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", 32'(bus.req_ready_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(bus.is_valid_o), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_sent", 32'(pkt_sent), 0);
        check("t6_data", 32'(bus.data_o), 0);
        @(posedge clk); #1;
        b = flits.size();
        push_req(5, 6, 0, 'h6666);
        wait_flits(b + 1);
        idle(6);
        check("t6_count", flits.size(), b + 1);
        check("t6_label", 32'(flits[b].flit_label), 32'(HEADTAIL));
        check("t6_vc", 32'(flits[b].vc_id), 0);
        check("t6_x", 32'(flits[b].data.head_data.x_dest), 5);
        check("t6_y", 32'(flits[b].data.head_data.y_dest), 6);
        check("t6_sent1", 32'(pkt_sent), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
